// File: rtl/load_align_unit_if.sv
// rtl/load_align_unit_if.sv - request, data-memory and response signals of the load align unit
interface load_align_unit_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            req_func3;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_rdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_data;
    logic                  resp_err;
    logic                  resp_split;

    modport slave (
        input  req_valid, req_addr, req_func3, mem_rdata, resp_ready,
        output req_ready, mem_en, mem_addr, resp_valid, resp_data, resp_err, resp_split
    );

    modport master (
        output req_valid, req_addr, req_func3, mem_rdata, resp_ready,
        input  req_ready, mem_en, mem_addr, resp_valid, resp_data, resp_err, resp_split
    );
endinterface

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - RV32I load alignment with split word reads and sign/zero extension
module load_align_unit #(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    load_align_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-3:0] base;
    logic [2:0]            func3;
    logic [1:0]            offset;
    logic                  split;
    logic                  err;
    logic                  beat;
    logic [2:0]            cnt;
    logic [31:0]           w0;
    logic [31:0]           resp_data;
    logic                  resp_err;
    logic                  resp_split;

    logic                  req_legal;
    logic                  req_split;
    logic                  last_cnt;
    logic [31:0]           cur_w0;
    logic [31:0]           cur_w1;
    logic [63:0]           shifted;
    logic [31:0]           ext;
    logic                  unused_hi;
    logic                  req_ready;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;

    assign req_legal = (bus.req_func3 == 3'b000) || (bus.req_func3 == 3'b001) ||
                       (bus.req_func3 == 3'b010) || (bus.req_func3 == 3'b100) ||
                       (bus.req_func3 == 3'b101);
    assign req_split = req_legal &&
                       (((bus.req_func3 == 3'b010) && (bus.req_addr[1:0] != 2'b00)) ||
                        ((bus.req_func3[1:0] == 2'b01) && (bus.req_addr[1:0] == 2'b11)));

    assign last_cnt = (cnt == LAT);

    // The final beat's word is taken straight from mem_rdata so the result can be registered on entry to RESP.
    assign cur_w0    = beat ? w0 : bus.mem_rdata;
    assign cur_w1    = (split && beat) ? bus.mem_rdata : 32'h0;
    assign shifted   = {cur_w1, cur_w0} >> {offset, 3'b000};
    assign unused_hi = ^shifted[63:32];

    // Extension of the aligned low bits according to the load type; illegal types return the raw word.
    always_comb begin
        ext = cur_w0;
        case (func3)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            3'b010:  ext = shifted[31:0];
            default: ext = cur_w0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the state-derived handshake and memory strobe.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_en     = 1'b1;
                mem_addr   = {base + {{(ADDR_WIDTH-3){1'b0}}, beat}, 2'b00};
                state_next = WAIT;
            end
            WAIT: begin
                if (last_cnt) begin
                    state_next = (!beat && split) ? ISSUE : RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, latency counting, beat sequencing and the registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base       <= '0;
            func3      <= 3'b000;
            offset     <= 2'b00;
            split      <= 1'b0;
            err        <= 1'b0;
            beat       <= 1'b0;
            cnt        <= 3'd0;
            w0         <= 32'h0;
            resp_data  <= 32'h0;
            resp_err   <= 1'b0;
            resp_split <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        base   <= bus.req_addr[ADDR_WIDTH-1:2];
                        func3  <= bus.req_func3;
                        offset <= bus.req_addr[1:0];
                        split  <= req_split;
                        err    <= !req_legal;
                        beat   <= 1'b0;
                    end
                end
                ISSUE: begin
                    cnt <= 3'd1;
                end
                WAIT: begin
                    if (last_cnt) begin
                        if (!beat) begin
                            w0 <= bus.mem_rdata;
                        end
                        if (!beat && split) begin
                            beat <= 1'b1;
                        end else begin
                            resp_data  <= ext;
                            resp_err   <= err;
                            resp_split <= split;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.mem_en     = mem_en;
    assign bus.mem_addr   = mem_addr;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = resp_data;
    assign bus.resp_err   = resp_err;
    assign bus.resp_split = resp_split;
endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - directed checks of load_align_unit at read latencies 1 and 3
module tb_load_align_unit;
    logic        clk;
    logic        rst_n;
    logic        use3;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [2:0]  req_func3;
    logic        resp_ready;
    logic [31:0] mw0;
    logic [31:0] mw1;
    int          n_pass;
    int          n_total;

    load_align_unit_if #(.ADDR_WIDTH(32)) b1 ();
    load_align_unit_if #(.ADDR_WIDTH(32)) b3 ();

    load_align_unit #(.RD_LATENCY(1), .ADDR_WIDTH(32)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    load_align_unit #(.RD_LATENCY(3), .ADDR_WIDTH(32)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign b1.req_valid  = req_valid & ~use3;
    assign b3.req_valid  = req_valid & use3;
    assign b1.req_addr   = req_addr;
    assign b3.req_addr   = req_addr;
    assign b1.req_func3  = req_func3;
    assign b3.req_func3  = req_func3;
    assign b1.resp_ready = resp_ready & ~use3;
    assign b3.resp_ready = resp_ready & use3;

    // Data memory models: words at 0x100/0x104 come from mw0/mw1, anything else reads 0xBAD00000.
    logic        p1_v;
    logic [31:0] p1_a;
    logic        p3_v [3];
    logic [31:0] p3_a [3];
    always @(posedge clk) begin
        p1_v    <= b1.mem_en;
        p1_a    <= b1.mem_addr;
        p3_v[0] <= b3.mem_en;
        p3_a[0] <= b3.mem_addr;
        p3_v[1] <= p3_v[0];
        p3_a[1] <= p3_a[0];
        p3_v[2] <= p3_v[1];
        p3_a[2] <= p3_a[1];
    end
    assign b1.mem_rdata = !p1_v ? 32'hDEADBEEF : (p1_a == 32'h100) ? mw0 :
                          (p1_a == 32'h104) ? mw1 : 32'hBAD00000;
    assign b3.mem_rdata = !p3_v[2] ? 32'hDEADBEEF : (p3_a[2] == 32'h100) ? mw0 :
                          (p3_a[2] == 32'h104) ? mw1 : 32'hBAD00000;

    logic        o_req_ready, o_mem_en, o_resp_valid, o_resp_err, o_resp_split;
    logic [31:0] o_mem_addr, o_resp_data;
    assign o_req_ready  = use3 ? b3.req_ready  : b1.req_ready;
    assign o_mem_en     = use3 ? b3.mem_en     : b1.mem_en;
    assign o_mem_addr   = use3 ? b3.mem_addr   : b1.mem_addr;
    assign o_resp_valid = use3 ? b3.resp_valid : b1.resp_valid;
    assign o_resp_data  = use3 ? b3.resp_data  : b1.resp_data;
    assign o_resp_err   = use3 ? b3.resp_err   : b1.resp_err;
    assign o_resp_split = use3 ? b3.resp_split : b1.resp_split;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_load(input string tag, input logic l3, input logic [31:0] a, input logic [2:0] f3,
                            input int hold, input logic [31:0] exp_data, input logic exp_err,
                            input logic exp_split, input int exp_cyc, input int exp_nmem,
                            input logic [31:0] exp_a0, input logic [31:0] exp_a1);
        int          nmem;
        int          rcyc;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d_first;
        use3 = l3;
        a0   = 32'hFFFFFFFF;
        a1   = 32'hFFFFFFFF;
        @(negedge clk);
        check({tag, " req_ready idle"}, 32'(o_req_ready), 32'd1);
        req_addr   = a;
        req_func3  = f3;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFFFFFF;
        req_func3 = 3'b000;
        nmem = 0;
        rcyc = -1;
        for (int k = 1; k <= 30 && rcyc < 0; k++) begin
            @(negedge clk);
            if (o_mem_en) begin
                if (nmem == 0) a0 = o_mem_addr;
                else a1 = o_mem_addr;
                nmem++;
            end
            if (o_resp_valid) rcyc = k;
        end
        check({tag, " resp cycle"}, 32'(rcyc), 32'(exp_cyc));
        check({tag, " mem_en count"}, 32'(nmem), 32'(exp_nmem));
        check({tag, " mem_addr0"}, a0, exp_a0);
        if (exp_nmem == 2) check({tag, " mem_addr1"}, a1, exp_a1);
        check({tag, " data"}, o_resp_data, exp_data);
        check({tag, " err"}, 32'(o_resp_err), 32'(exp_err));
        check({tag, " split"}, 32'(o_resp_split), 32'(exp_split));
        d_first = o_resp_data;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 32'(o_resp_valid), 32'd1);
            check({tag, " hold data"}, o_resp_data, d_first);
        end
        check({tag, " req_ready busy"}, 32'(o_req_ready), 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, " req_ready after"}, 32'(o_req_ready), 32'd1);
        check({tag, " valid after"}, 32'(o_resp_valid), 32'd0);
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        use3       = 1'b0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_func3  = 3'b000;
        resp_ready = 1'b0;
        mw0        = 32'h0;
        mw1        = 32'h0;
        repeat (2) @(negedge clk);
        check("rst mem_en", 32'(b1.mem_en), 32'd0);
        check("rst mem_addr", b1.mem_addr, 32'h0);
        check("rst resp_valid", 32'(b1.resp_valid), 32'd0);
        check("rst resp_data", b1.resp_data, 32'h0);
        check("rst resp_err", 32'(b1.resp_err), 32'd0);
        check("rst resp_split", 32'(b1.resp_split), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst req_ready", 32'(b1.req_ready), 32'd1);

        mw0 = 32'h80FF7F01;
        run_load("lb103",  1'b0, 32'h103, 3'b000, 0, 32'hFFFFFF80, 1'b0, 1'b0, 3, 1, 32'h100, 32'h0);
        run_load("lhu102", 1'b0, 32'h102, 3'b101, 0, 32'h000080FF, 1'b0, 1'b0, 3, 1, 32'h100, 32'h0);
        run_load("lh102",  1'b0, 32'h102, 3'b001, 0, 32'hFFFF80FF, 1'b0, 1'b0, 3, 1, 32'h100, 32'h0);
        run_load("lbu101", 1'b0, 32'h101, 3'b100, 0, 32'h0000007F, 1'b0, 1'b0, 3, 1, 32'h100, 32'h0);
        run_load("lw100",  1'b0, 32'h100, 3'b010, 0, 32'h80FF7F01, 1'b0, 1'b0, 3, 1, 32'h100, 32'h0);
        run_load("hold",   1'b0, 32'h100, 3'b000, 4, 32'h00000001, 1'b0, 1'b0, 3, 1, 32'h100, 32'h0);
        run_load("ill011", 1'b0, 32'h102, 3'b011, 0, 32'h80FF7F01, 1'b1, 1'b0, 3, 1, 32'h100, 32'h0);

        mw0 = 32'h44332211;
        mw1 = 32'h88776655;
        run_load("lw101",  1'b0, 32'h101, 3'b010, 0, 32'h55443322, 1'b0, 1'b1, 5, 2, 32'h100, 32'h104);
        run_load("lh103",  1'b0, 32'h103, 3'b001, 0, 32'h00005544, 1'b0, 1'b1, 5, 2, 32'h100, 32'h104);
        run_load("lw103",  1'b0, 32'h103, 3'b010, 0, 32'h77665544, 1'b0, 1'b1, 5, 2, 32'h100, 32'h104);
        run_load("lhu102b", 1'b0, 32'h102, 3'b101, 0, 32'h00004433, 1'b0, 1'b0, 3, 1, 32'h100, 32'h0);
        run_load("ill111", 1'b0, 32'h103, 3'b111, 0, 32'h44332211, 1'b1, 1'b0, 3, 1, 32'h100, 32'h0);
        run_load("wrap",   1'b0, 32'hFFFFFFFE, 3'b010, 0, 32'h0000BAD0, 1'b0, 1'b1, 5, 2, 32'hFFFFFFFC, 32'h0);
        run_load("l3lh103", 1'b1, 32'h103, 3'b001, 2, 32'h00005544, 1'b0, 1'b1, 9, 2, 32'h100, 32'h104);
        run_load("l3lb100", 1'b1, 32'h100, 3'b000, 0, 32'h00000011, 1'b0, 1'b0, 5, 1, 32'h100, 32'h0);

        // Reset pulsed while the latency-3 unit waits for read data.
        use3 = 1'b1;
        mw0  = 32'h12345678;
        @(negedge clk);
        req_addr  = 32'h100;
        req_func3 = 3'b010;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rstmid issue mem_en", 32'(b3.mem_en), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid mem_en", 32'(b3.mem_en), 32'd0);
        check("rstmid resp_valid", 32'(b3.resp_valid), 32'd0);
        check("rstmid req_ready", 32'(b3.req_ready), 32'd1);
        check("rstmid resp_data", b3.resp_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rstmid later valid", 32'(b3.resp_valid), 32'd0);
        check("rstmid later data", b3.resp_data, 32'h0);
        run_load("l3after", 1'b1, 32'h100, 3'b010, 0, 32'h12345678, 1'b0, 1'b0, 5, 1, 32'h100, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
